// File: rtl/friscv_inst_prefetch_if.sv
// rtl/friscv_inst_prefetch_if.sv - en/ready read channel (request address, returned word)
interface friscv_inst_prefetch_if #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
) ();
    logic             en;
    logic [ADDRW-1:0] addr;
    logic [XLEN-1:0]  rdata;
    logic             ready;

    // Requester side: drives the request, receives data and completion.
    modport master (output en, output addr, input rdata, input ready);

    // Responder side: receives the request, returns data and completion.
    modport slave (input en, input addr, output rdata, output ready);
endinterface

// File: rtl/friscv_inst_prefetch.sv
// rtl/friscv_inst_prefetch.sv - sequential instruction prefetch FIFO between core fetch port and instruction memory
module friscv_inst_prefetch #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 16,
    parameter int DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   srst,
    friscv_inst_prefetch_if.slave  inst,
    friscv_inst_prefetch_if.master mem
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [ADDRW-1:0] WORD_STEP = ADDRW'(4);
    localparam logic [ADDRW-1:0] ALIGN_MASK = ~ADDRW'(3);
    localparam logic [CNTW-1:0]  FULL = CNTW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state;
    logic [XLEN-1:0]  fifo [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  count;
    logic [ADDRW-1:0] head_addr;
    logic [ADDRW-1:0] fetch_addr;
    logic [ADDRW-1:0] drain_addr;

    logic [ADDRW-1:0] req_addr;
    logic             addr_match;
    logic             hit;
    logic             miss;
    logic             mem_hs;
    logic             push;

    // head_addr is always word aligned, so comparing the masked request covers bits [ADDRW-1:2]
    assign req_addr   = inst.addr & ALIGN_MASK;
    assign addr_match = (req_addr == head_addr);
    assign hit        = inst.en && (state == FETCH) && (count != '0) && addr_match;
    assign miss       = inst.en && !((state == FETCH) && addr_match);

    // Memory request depends on flops only, so it cannot drop while a handshake is pending
    assign mem.en   = ((state == FETCH) && (count < FULL)) || (state == DRAIN);
    assign mem.addr = (state == DRAIN) ? drain_addr : fetch_addr;
    assign mem_hs   = mem.en && mem.ready;
    // A flush in the same cycle as a handshake wins: the returned word is dropped
    assign push     = mem_hs && (state == FETCH) && !miss;

    assign inst.ready = hit;
    assign inst.rdata = (count != '0) ? fifo[rd_ptr] : '0;

    // FIFO storage: data needs no reset, validity is tracked by count
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo[wr_ptr] <= mem.rdata;
        end
    end

    // Control FSM, pointers, occupancy and stream addresses
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_addr  <= '0;
            fetch_addr <= '0;
            drain_addr <= '0;
        end else if (srst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_addr  <= '0;
            fetch_addr <= '0;
            drain_addr <= '0;
        end else if (miss) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_addr  <= req_addr;
            fetch_addr <= req_addr;
            // In DRAIN mem.addr is already drain_addr, so the outstanding request is kept
            drain_addr <= mem.addr;
            if (mem.en && !mem.ready) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (push) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        fetch_addr <= fetch_addr + WORD_STEP;
                    end
                    if (hit) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        head_addr <= head_addr + WORD_STEP;
                    end
                    case ({push, hit})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
                DRAIN: begin
                    if (mem.ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/friscv_inst_prefetch.md
# friscv_inst_prefetch

Instruction prefetch buffer between the RV32I control unit's instruction fetch port and the instruction memory. It streams sequential words from memory into a small FIFO ahead of the program counter, so sequential fetches complete in the request cycle. A fetch to any other address flushes the buffer and restarts the stream at that address. The core side and the memory side both use the codebase's en/ready handshake.

## Interface
- XLEN, 32: instruction width.
- ADDRW, 16: byte address width (core and memory side).
- DEPTH, 4: FIFO entries; power of two, ≥2.

Ports:
- aclk  in  1: single clock; everything is on the rising edge.
- areset  in  1: asynchronous, active-high reset.
- srst  in  1: synchronous active-high reset; same effect as areset.
- inst_en  in  1: core fetch request.
- inst_addr  in  ADDRW: core fetch byte address; bits [1:0] ignored.
- inst_rdata  out  XLEN: instruction, valid when inst_ready=1.
- inst_ready  out  1: core handshake complete.
- mem_en  out  1: memory read request.
- mem_addr  out  ADDRW: memory word address (bits [1:0]=0).
- mem_rdata  in  XLEN: memory data, valid with mem_ready.
- mem_ready  in  1: memory handshake complete.

## Operation
- Handshake rule, both sides: a transfer happens when en and ready are both 1 in the same cycle, and rdata is sampled in that cycle. The requester holds en and addr stable until ready.
- State is held in flops: the FIFO (DEPTH words), count (0..DEPTH), head_addr (address of the FIFO head), fetch_addr (next word to fetch), and an FSM with states IDLE, FETCH, DRAIN.
- **Hit:** inst_en=1, count>0, FSM in FETCH, and inst_addr[ADDRW-1:2]==head_addr[ADDRW-1:2].
  - inst_ready=1 and inst_rdata=FIFO head.
  - The head is popped and head_addr+=4.
- **Wait:** inst_en=1, FSM in FETCH, count==0 and the address matches head_addr. Then inst_ready=0 and no state changes.
- **Miss:** inst_en=1 with any other condition, including IDLE, an address mismatch, or DRAIN with a new target.
  - inst_ready=0; count←0; head_addr←fetch_addr←{inst_addr[ADDRW-1:2],2'b00}.
  - If mem_en=1 and mem_ready=0 in that cycle, the FSM goes to DRAIN. Otherwise it goes to FETCH.
- **Memory side:**
  - mem_en = (FETCH && count<DEPTH) || DRAIN, derived from flops only.
  - mem_addr = fetch_addr in FETCH. In DRAIN it is the address latched for the outstanding request.
  - FETCH, handshake: push mem_rdata, fetch_addr+=4.
  - DRAIN, handshake: discard the data and go to FETCH (now fetching from the new fetch_addr).
- **Redirect during DRAIN:** updates head_addr and fetch_addr only. The outstanding request stays unchanged.
- **Simultaneous events:**
  - Push and pop in the same cycle leave count unchanged.
  - A miss in the same cycle as a FETCH memory handshake discards that data; the flush wins.
- **Wrap-around:** fetch_addr and head_addr increment modulo 2^ADDRW.
- **Full:** when count==DEPTH, mem_en=0 in FETCH. mem_en never drops while its handshake is pending, because count only rises on a handshake.
- **IDLE:** entered only from reset. mem_en=0.

## Timing
- Reset values (areset or srst): FSM=IDLE, count=0, head_addr=fetch_addr=0, inst_ready=0, inst_rdata=0, mem_en=0, mem_addr=0. Outputs are 0 immediately on areset assertion.
- Reset mid-operation drops all FIFO content and any outstanding memory request.
- inst_rdata = FIFO head when count>0, else 0.
- Hit latency is 0 cycles: inst_ready is combinational from inst_en, inst_addr and flops.
- Miss at cycle N, memory with zero wait states:
  - N+1: mem_en=1, mem_ready=1 (first word pushed).
  - N+2: inst_ready=1.
- Each memory wait cycle adds one cycle. A redirect that causes a DRAIN adds the drain wait as well.
- Sustained throughput is one instruction per cycle when memory returns one word per cycle.

## Test plan
- Stream: request 0x0, 0x4, 0x8… with memory always ready and word=addr.
  - First inst_ready at 2 cycles after request, then 1 per cycle.
  - rdata = 0x0, 0x4, 0x8.
- Full: DEPTH=4, inst_en=0 after the first fetch. mem_en drops once count=4; mem_addr advances only to 0x14. Then 4 back-to-back hits with zero-cycle ready.
- Redirect: request to 0x100 while FIFO holds 0x10–0x1C.
  - Flush; mem_addr=0x100 next cycle; inst_rdata=mem[0x100] two cycles later.
  - Old data is never returned.
- Drain: memory stalls 3 cycles on 0x20 when the core redirects to 0x200.
  - mem_addr stays 0x20 until mem_ready and that data is discarded.
  - The next mem_addr is 0x200, and the core receives mem[0x200].
- Wrap: ADDRW=16, start at 0xFFF8. mem_addr sequence 0xFFF8, 0xFFFC, 0x0000; hits continue across the wrap.
- Reset: assert areset mid-stream with mem_en=1. mem_en, inst_ready and count go to 0 asynchronously, and the next request behaves as a miss.
